// File: rtl/yi_writer_if.sv
// rtl/yi_writer_if.sv - Yi beat stream and AXI4 write channels bundled for yi_writer
//
// Purpose: groups the input beat handshake and the AXI4 AW/W/B channels
// used by yi_writer into one bundle.
//   master modport : the writer side (consumes input beats, drives AW/W, accepts B)
//   slave modport  : the environment side (beat producer plus AXI memory slave)
// Signals:
//   input_valid/input_ready/input_data : 256-bit Yi beat stream, word 0 in [63:0]
//   m_axi_Yi_aw*                       : write address channel
//   m_axi_Yi_w*                        : write data channel
//   m_axi_Yi_b*                        : write response channel

interface yi_writer_if;
  logic         input_valid;
  logic         input_ready;
  logic [255:0] input_data;

  logic         m_axi_Yi_awid;
  logic [47:0]  m_axi_Yi_awaddr;
  logic [7:0]   m_axi_Yi_awlen;
  logic [2:0]   m_axi_Yi_awsize;
  logic [1:0]   m_axi_Yi_awburst;
  logic         m_axi_Yi_awlock;
  logic [3:0]   m_axi_Yi_awcache;
  logic [2:0]   m_axi_Yi_awprot;
  logic [3:0]   m_axi_Yi_awqos;
  logic         m_axi_Yi_awvalid;
  logic         m_axi_Yi_awready;

  logic [255:0] m_axi_Yi_wdata;
  logic [31:0]  m_axi_Yi_wstrb;
  logic         m_axi_Yi_wlast;
  logic         m_axi_Yi_wvalid;
  logic         m_axi_Yi_wready;

  logic         m_axi_Yi_bid;
  logic [1:0]   m_axi_Yi_bresp;
  logic         m_axi_Yi_bvalid;
  logic         m_axi_Yi_bready;

  modport master (
    input  input_valid, input_data,
    output input_ready,
    output m_axi_Yi_awid, m_axi_Yi_awaddr, m_axi_Yi_awlen, m_axi_Yi_awsize,
    output m_axi_Yi_awburst, m_axi_Yi_awlock, m_axi_Yi_awcache, m_axi_Yi_awprot,
    output m_axi_Yi_awqos, m_axi_Yi_awvalid,
    input  m_axi_Yi_awready,
    output m_axi_Yi_wdata, m_axi_Yi_wstrb, m_axi_Yi_wlast, m_axi_Yi_wvalid,
    input  m_axi_Yi_wready,
    input  m_axi_Yi_bid, m_axi_Yi_bresp, m_axi_Yi_bvalid,
    output m_axi_Yi_bready
  );

  modport slave (
    output input_valid, input_data,
    input  input_ready,
    input  m_axi_Yi_awid, m_axi_Yi_awaddr, m_axi_Yi_awlen, m_axi_Yi_awsize,
    input  m_axi_Yi_awburst, m_axi_Yi_awlock, m_axi_Yi_awcache, m_axi_Yi_awprot,
    input  m_axi_Yi_awqos, m_axi_Yi_awvalid,
    output m_axi_Yi_awready,
    input  m_axi_Yi_wdata, m_axi_Yi_wstrb, m_axi_Yi_wlast, m_axi_Yi_wvalid,
    output m_axi_Yi_wready,
    output m_axi_Yi_bid, m_axi_Yi_bresp, m_axi_Yi_bvalid,
    input  m_axi_Yi_bready
  );
endinterface

// File: rtl/yi_writer.sv
// rtl/yi_writer.sv - AXI4 write master draining the packed 256-bit Yi result stream
//
// Purpose: buffers 256-bit Yi beats in a FIFO and writes them to memory as
// INCR bursts of at most MAX_BURST beats, starting at YVAL_BASE_ADDR.
// Ports:
//   clk          : clock
//   rstn         : asynchronous active-low reset
//   Write_Begin  : start pulse, honoured only when idle
//   Write_Length : job length in beats, latched with Write_Begin
//   Write_Done   : one-cycle pulse at job completion or abort
//   Write_Err    : sticky error flag, cleared by the next accepted Write_Begin
//   yi           : yi_writer_if.master (beat stream + AXI AW/W/B channels)
// Option: define YI_WRITER_BRESP_CHK_EN to abort a job on a non-OKAY bresp.

module yi_writer #(
  parameter logic [31:0] YVAL_BASE_ADDR = 32'h4000_0000,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          MAX_BURST      = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          Write_Begin,
  input  logic [31:0]   Write_Length,
  output logic          Write_Done,
  output logic          Write_Err,
  yi_writer_if.master   yi
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t       state_q;
  logic [31:0]  remain_q;
  logic [31:0]  in_left_q;
  logic [47:0]  addr_q;
  logic [8:0]   blen_q;
  logic [7:0]   awlen_q;
  logic [7:0]   beat_q;
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         done_q;
  logic [255:0] mem_q [FIFO_DEPTH];

  logic [31:0]  remain_d;
  logic [8:0]   blen_d;
  logic [AW:0]  fifo_count;
  logic         fifo_full;
  logic         busy;
  logic         push;
  logic         pop;
  logic         aw_fire;
  logic         unused_bits;

  function automatic logic [8:0] burst_len(input logic [31:0] n);
    if (n >= 32'(MAX_BURST)) return 9'(MAX_BURST);
    return n[8:0];
  endfunction

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_count == DEPTH_C);
  assign busy       = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_RESP);

  assign yi.input_ready = busy && !fifo_full && (in_left_q != 32'd0);
  assign push           = yi.input_valid && yi.input_ready;
  assign pop            = yi.m_axi_Yi_wvalid && yi.m_axi_Yi_wready;

  // The address is only offered once the whole burst is buffered, so the W
  // channel can never run dry mid-burst. Count only grows while in ADDR,
  // which keeps awvalid high once raised.
  assign yi.m_axi_Yi_awvalid = (state_q == S_ADDR) && (9'(fifo_count) >= blen_q);
  assign aw_fire             = yi.m_axi_Yi_awvalid && yi.m_axi_Yi_awready;

  assign yi.m_axi_Yi_awid    = 1'b0;
  assign yi.m_axi_Yi_awaddr  = addr_q;
  assign yi.m_axi_Yi_awlen   = awlen_q;
  assign yi.m_axi_Yi_awsize  = 3'b101;
  assign yi.m_axi_Yi_awburst = 2'b01;
  assign yi.m_axi_Yi_awlock  = 1'b0;
  assign yi.m_axi_Yi_awcache = 4'b0011;
  assign yi.m_axi_Yi_awprot  = 3'b000;
  assign yi.m_axi_Yi_awqos   = 4'b0000;

  assign yi.m_axi_Yi_wvalid  = (state_q == S_DATA);
  assign yi.m_axi_Yi_wdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign yi.m_axi_Yi_wstrb   = '1;
  assign yi.m_axi_Yi_wlast   = (state_q == S_DATA) && (beat_q == awlen_q);

  assign yi.m_axi_Yi_bready  = (state_q == S_RESP);

  assign Write_Done = done_q;

  // bid is not checked: only one burst is ever outstanding.
  assign unused_bits = ^{yi.m_axi_Yi_bid, yi.m_axi_Yi_bresp};

  // Length of the burst to issue next: from the new job in IDLE, otherwise
  // from what is left after the burst being acknowledged.
  always_comb begin
    remain_d = remain_q - 32'(blen_q);
    blen_d   = burst_len((state_q == S_IDLE) ? Write_Length : remain_d);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= yi.input_data;
  end

`ifdef YI_WRITER_BRESP_CHK_EN
  logic err_q;
  assign Write_Err = err_q;
`else
  assign Write_Err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      remain_q  <= 32'd0;
      in_left_q <= 32'd0;
      addr_q    <= 48'd0;
      blen_q    <= 9'd0;
      awlen_q   <= 8'd0;
      beat_q    <= 8'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      done_q    <= 1'b0;
`ifdef YI_WRITER_BRESP_CHK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + PTR_ONE;
        in_left_q <= in_left_q - 32'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;

      unique case (state_q)
        S_IDLE: begin
          if (Write_Begin) begin
            remain_q  <= Write_Length;
            in_left_q <= Write_Length;
            addr_q    <= {16'd0, YVAL_BASE_ADDR};
            blen_q    <= blen_d;
            beat_q    <= 8'd0;
`ifdef YI_WRITER_BRESP_CHK_EN
            err_q     <= 1'b0;
`endif
            if (Write_Length == 32'd0) begin
              state_q <= S_DONE;
            end else begin
              // A 256-beat burst has blen_d[7:0] == 0, so this wraps to 255.
              awlen_q <= blen_d[7:0] - 8'd1;
              state_q <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (aw_fire) begin
            beat_q  <= 8'd0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (pop) begin
            beat_q <= beat_q + 8'd1;
            if (yi.m_axi_Yi_wlast) state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (yi.m_axi_Yi_bvalid) begin
`ifdef YI_WRITER_BRESP_CHK_EN
            if (yi.m_axi_Yi_bresp != 2'b00) begin
              // Abort: drop buffered beats and stop accepting more.
              err_q     <= 1'b1;
              in_left_q <= 32'd0;
              wr_ptr_q  <= '0;
              rd_ptr_q  <= '0;
              state_q   <= S_DONE;
            end else begin
`else
            begin
`endif
              remain_q <= remain_d;
              addr_q   <= addr_q + 48'({blen_q, 5'b00000});
              if (remain_d == 32'd0) begin
                state_q <= S_DONE;
              end else begin
                blen_q  <= blen_d;
                awlen_q <= blen_d[7:0] - 8'd1;
                state_q <= S_ADDR;
              end
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
